pipeline_hazard_ctrl: RTL

//  Hazard/stall/flush controller for the vector pipeline. Sits beside the IF_ID and ID_EXE

---
 rtl/pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard / stall / flush controller for the vector pipeline. Drives
//            the IF_ID and ID_EXE stop/flush controls, the PC hold and the
//            ID-stage operand forwarding selects. Resolves load-use and RAW
//            hazards, taken branch/jump redirects and data-memory wait states,
//            and keeps a saturating count of PC-hold cycles.
// Config   : FORWARDING_EN - when defined, EXE/MEM results are forwarded and
//            only load-use hazards stall; when undefined, forwarding selects
//            stay 00 and every RAW match against EXE or MEM stalls.
// Ports    : clk, reset (sync, active-low)
//            rs1_id, rs2_id, rs_used_id          - ID-stage source operands
//            rd_exe, regWrite_exe, resultSrc_exe  - EXE-stage writer
//            rd_mem, regWrite_mem                 - MEM-stage writer
//            branch_taken_exe, jump_exe           - redirect requests
//            mem_busy                             - data memory wait
//            stop_pc, stop_ifid, stop_idexe       - hold controls
//            flush_ifid, flush_idexe              - clear controls
//            fwdA, fwdB                           - 00 RF, 10 EXE, 01 MEM
//            stall_count                          - saturating stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int RW           = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RW-1:0]    rs1_id,
  input  logic [RW-1:0]    rs2_id,
  input  logic [1:0]       rs_used_id,
  input  logic [RW-1:0]    rd_exe,
  input  logic             regWrite_exe,
  input  logic             resultSrc_exe,
  input  logic [RW-1:0]    rd_mem,
  input  logic             regWrite_mem,
  input  logic             branch_taken_exe,
  input  logic             jump_exe,
  input  logic             mem_busy,
  output logic             stop_pc,
  output logic             stop_ifid,
  output logic             stop_idexe,
  output logic             flush_ifid,
  output logic             flush_idexe,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_count
);

  localparam int C_FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [C_FCNT_W-1:0] C_FLUSH_FULL   = C_FCNT_W'(FLUSH_CYCLES);
  localparam logic [C_FCNT_W-1:0] C_FLUSH_RELOAD = C_FCNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [C_FCNT_W-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic                r_pend_redir, w_pend_redir_nxt;
  logic [CNT_W-1:0]    r_stall_count;

  logic       w_redirect;
  logic       w_rs1_live, w_rs2_live;
  logic       w_exe_wr, w_mem_wr;
  logic       w_load_use;
  logic       w_hazard;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_do_run;

  assign w_redirect = branch_taken_exe | jump_exe;

  // Index 0 is hard-wired zero: never a dependency or a forwarding source.
  assign w_rs1_live = rs_used_id[0] && (rs1_id != '0);
  assign w_rs2_live = rs_used_id[1] && (rs2_id != '0);
  assign w_exe_wr   = regWrite_exe && (rd_exe != '0);
  assign w_mem_wr   = regWrite_mem && (rd_mem != '0);

  assign w_load_use = w_exe_wr && resultSrc_exe &&
                      ((w_rs1_live && (rd_exe == rs1_id)) ||
                       (w_rs2_live && (rd_exe == rs2_id)));

`ifdef FORWARDING_EN
  assign w_hazard = w_load_use;

  // Forwarding is not qualified by rs_used_id: an unused operand's mux
  // setting is don't-care downstream. EXE wins over MEM (younger result).
  assign w_fwd_a = (regWrite_exe && !resultSrc_exe && (rd_exe == rs1_id) && (rs1_id != '0)) ? 2'b10 :
                   (regWrite_mem && (rd_mem == rs1_id) && (rs1_id != '0))                   ? 2'b01 :
                                                                                               2'b00;
  assign w_fwd_b = (regWrite_exe && !resultSrc_exe && (rd_exe == rs2_id) && (rs2_id != '0)) ? 2'b10 :
                   (regWrite_mem && (rd_mem == rs2_id) && (rs2_id != '0))                   ? 2'b01 :
                                                                                               2'b00;
`else
  logic w_raw;

  // Without bypass paths any in-flight writer of a read register stalls ID;
  // the match migrates EXE -> MEM so the stall lasts at most two cycles.
  assign w_raw = (w_rs1_live && ((w_exe_wr && (rd_exe == rs1_id)) || (w_mem_wr && (rd_mem == rs1_id)))) ||
                 (w_rs2_live && ((w_exe_wr && (rd_exe == rs2_id)) || (w_mem_wr && (rd_mem == rs2_id))));
  assign w_hazard = w_load_use | w_raw;
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
`endif

  always_comb begin
    stop_pc          = 1'b0;
    stop_ifid        = 1'b0;
    stop_idexe       = 1'b0;
    flush_ifid       = 1'b0;
    flush_idexe      = 1'b0;
    fwdA             = w_fwd_a;
    fwdB             = w_fwd_b;
    w_state_nxt      = r_state;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_pend_redir_nxt = r_pend_redir;
    w_do_run         = 1'b0;

    if (mem_busy) begin
      // Whole front end freezes; a redirect arriving now is remembered and
      // replayed as a full flush once memory is ready.
      stop_pc          = 1'b1;
      stop_ifid        = 1'b1;
      stop_idexe       = 1'b1;
      fwdA             = 2'b00;
      fwdB             = 2'b00;
      w_state_nxt      = S_MEM_WAIT;
      w_pend_redir_nxt = r_pend_redir | w_redirect;
    end else begin
      case (r_state)
        S_MEM_WAIT: begin
          w_pend_redir_nxt = 1'b0;
          if (r_pend_redir) begin
            // Release cycle of a deferred redirect: the fetched path is
            // discarded by the following FLUSH cycles, so nothing else acts.
            fwdA            = 2'b00;
            fwdB            = 2'b00;
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = C_FLUSH_FULL;
          end else begin
            // Plain release: the ID instruction advances now, so it needs
            // the normal hazard and forwarding decode.
            w_do_run = 1'b1;
          end
        end
        S_FLUSH: begin
          flush_ifid = 1'b1;
          if (w_redirect) begin
            flush_idexe     = 1'b1;
            w_flush_cnt_nxt = C_FLUSH_RELOAD;
            w_state_nxt     = (C_FLUSH_RELOAD == '0) ? S_RUN : S_FLUSH;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
            if (r_flush_cnt <= C_FCNT_W'(1)) begin
              w_state_nxt = S_RUN;
            end
          end
        end
        default: begin
          w_do_run = 1'b1;
        end
      endcase
    end

    if (w_do_run) begin
      w_state_nxt = S_RUN;
      if (w_redirect) begin
        flush_ifid      = 1'b1;
        flush_idexe     = 1'b1;
        w_flush_cnt_nxt = C_FLUSH_RELOAD;
        w_state_nxt     = (C_FLUSH_RELOAD == '0) ? S_RUN : S_FLUSH;
      end else if (w_hazard) begin
        // Hold IF/ID, let ID_EXE take a bubble for one cycle.
        stop_pc     = 1'b1;
        stop_ifid   = 1'b1;
        flush_idexe = 1'b1;
      end
    end

    if (!reset) begin
      stop_pc     = 1'b0;
      stop_ifid   = 1'b0;
      stop_idexe  = 1'b0;
      flush_ifid  = 1'b0;
      flush_idexe = 1'b0;
      fwdA        = 2'b00;
      fwdB        = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_flush_cnt   <= '0;
      r_pend_redir  <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_pend_redir <= w_pend_redir_nxt;
      if (stop_pc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  assign stall_count = r_stall_count;

endmodule
`default_nettype wire
